mem_arbiter: RTL
================

# mem_arbiter

Byte-serial memory controller between the CPU core and the single-port, byte-wide RAM/IO bus. It serves two requesters: instruction-cache line refills (8 bytes) and load/store-unit accesses (1/2/4 bytes). It arbitrates between them, sequences one byte per cycle onto the bus, assembles read data little-endian, and throttles IO writes on `io_buffer_full`. It sits at the bottom of the memory hierarchy, below the instruction cache and the LSB.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `IO_HI`, 2'b11, value of `addr[17:16]` that selects the IO region

Ports:
- `clk` in 1, system clock
- `rst` in 1, asynchronous, active-high reset
- `rdy` in 1, global enable; low freezes the block
- `clear` in 1, mispredict flush; aborts an icache refill
- `mem_din` in 8, RAM read byte
- `mem_dout` out 8, RAM write byte
- `mem_a` out 32, RAM byte address
- `mem_wr` out 1, 1 = write, 0 = read
- `io_buffer_full` in 1, IO output buffer full
- `ic_en` in 1, icache refill request (level)
- `ic_addr` in 32, refill address, 8-byte aligned
- `ic_valid` out 1, one-cycle refill-done pulse
- `ic_blk` out 64, refilled line; byte 0 in bits [7:0]
- `ls_en` in 1, LSB request (level)
- `ls_wr` in 1, 1 = store
- `ls_width` in 2, 00 byte, 01 half, 10 word
- `ls_addr` in 32, access address; any alignment
- `ls_wdata` in 32, store data; low bytes used
- `ls_valid` out 1, one-cycle done pulse
- `ls_rdata` out 32, load data, zero-extended; sign extension is the LSB's job

## Operation
- States: IDLE, IC_RD, LS_RD, LS_WR, DONE.
- IDLE: if `ls_en`, latch the LS request and go to LS_RD or LS_WR. Else if `ic_en` and not `clear`, latch `ic_addr` and go to IC_RD. LSB has fixed priority.
- Byte count N: 8 for IC; 1, 2 or 4 for LS per `ls_width`. Address counter k runs 0..N-1, and byte k uses address base+k (32-bit wrap).
- Reads: byte k is issued at cycle k after acceptance and captured from `mem_din` one cycle later, into byte lane k. After byte N-1 is captured, go to DONE.
- Writes: byte k is driven on `mem_a`/`mem_dout` with `mem_wr`=1 for one cycle. After N bytes, go to DONE.
- IO throttle: if the write target has `addr[17:16]==IO_HI` and `io_buffer_full` is high at the issuing edge, the byte is not issued. `mem_wr`=0, `mem_a`=0, and k holds.
- DONE: pulse `ic_valid` or `ls_valid` for exactly one cycle, then return to IDLE. Requesters drop `en` during this pulse cycle, so IDLE sees the fresh level.
- `ic_blk` and `ls_rdata` hold their last value until the next completion of the same requester.
- No-issue rule: whenever no byte is being issued, `mem_a`=0 and `mem_wr`=0. An IO read must occur exactly once, since a read consumes input.
- `clear` in IC_RD: go to IDLE next edge, no `ic_valid`, in-flight byte discarded.
- `clear` has no effect on LS_RD and LS_WR; LS accesses always complete.
- `rdy` low: all registers hold and `mem_wr` is forced 0. The system keeps `mem_din` stable while `rdy` is low.
- Reset: state IDLE, and every output is 0.

## Timing
- Outputs `mem_a`, `mem_dout`, `mem_wr` are registered. Valid pulses are registered.
- Latency from an IDLE cycle c with the request seen to the valid pulse is c+N+2:
  - icache refill: c+10
  - word load: c+6
  - byte load: c+3
- Stores complete at c+N+1 plus IO stall cycles.
- Minimum gap between back-to-back accesses: one IDLE cycle after DONE.
- Simultaneous `ic_en` and `ls_en`: the LS access is served first. IC is taken at the next IDLE if still requested.
- `clear` together with `ic_en` in IDLE: no IC access starts. An LS request still starts.

## Structure
- Shared package `mem_pkg` holds:
  - state enum
  - width codes (`W_BYTE`, `W_HALF`, `W_WORD`)
  - `IO_HI`
  - line size constant 8, shared with the instruction cache
- Single module. The byte assembler and counter are small enough inline, so no sub-module.

## Test plan
- Reset mid-write: assert `rst` during LS_WR byte 2 → immediately `mem_wr`=0, `mem_a`=0, both valids 0, state IDLE.
- Icache refill: `ic_en`, `ic_addr`=0x1000, RAM[0x1000+i]=i → `mem_a` steps 0x1000..0x1007 in 8 consecutive cycles; `ic_valid` pulses once at c+10 with `ic_blk`=0x0706050403020100.
- Simultaneous requests: `ls_en` word load at 0x2002 and `ic_en` 0x0 in the same cycle → LS first, `ls_rdata`=bytes 0x2002..0x2005 little-endian. IC starts only after the LS DONE plus one IDLE cycle.
- IO store stall: store byte 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` stays 0 for those cycles, then one write of 0x41, then `ls_valid`. There is no spurious read of 0x30000 at any time.
- Flush during refill: `clear` during IC_RD byte 3 → no `ic_valid`, `mem_a`=0 next cycle, IDLE. A following LS request is served normally.
- Half store at unaligned 0x1FFF with `ls_wdata`=0xABCD → writes 0xCD@0x1FFF and 0xAB@0x2000. `ls_valid` pulses once.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory controller and its clients.
// LINE_BYTES is also the instruction-cache line size.
package mem_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_IC_RD,
      S_LS_RD,
      S_LS_WR,
      S_DONE
   } state_e;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   localparam logic [1:0] IO_HI      = 2'b11;
   localparam int         LINE_BYTES = 8;

   // Byte count of an LSB access; the unused width code behaves as a word.
   function automatic logic [3:0] ls_bytes(input logic [1:0] w);
      case (w)
         W_BYTE:  ls_bytes = 4'd1;
         W_HALF:  ls_bytes = 4'd2;
         default: ls_bytes = 4'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache refills and LSB accesses onto a byte-wide RAM/IO bus,
// one byte per cycle, assembling read data little-endian.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = mem_pkg::IO_HI
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clear,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full,
   input  logic              ic_en,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_valid,
   output logic [63:0]       ic_blk,
   input  logic              ls_en,
   input  logic              ls_wr,
   input  logic [1:0]        ls_width,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_valid,
   output logic [31:0]       ls_rdata
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        n_q, n_d;        // bytes in this access
   logic [3:0]        k_q, k_d;        // bytes issued so far
   logic [3:0]        cap_q, cap_d;    // read bytes captured so far
   logic [31:0]       wdata_q, wdata_d;
   logic [63:0]       asm_q, asm_d;
   logic [63:0]       ic_blk_q, ic_blk_d;
   logic [31:0]       ls_rdata_q, ls_rdata_d;
   logic              ic_valid_q, ic_valid_d;
   logic              ls_valid_q, ls_valid_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        mem_dout_q, mem_dout_d;
   logic              mem_wr_q, mem_wr_d;
   // iss_q: a read byte is on the bus now; dv_q: its data is on mem_din now.
   logic              iss_q, iss_d;
   logic              dv_q, dv_d;

   logic              rd_go, wr_go;
   logic [ADDR_W-1:0] ib, tgt;
   logic [3:0]        ik;
   logic [31:0]       wd;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      n_d        = n_q;
      k_d        = k_q;
      cap_d      = cap_q;
      wdata_d    = wdata_q;
      asm_d      = asm_q;
      ic_blk_d   = ic_blk_q;
      ls_rdata_d = ls_rdata_q;
      ic_valid_d = 1'b0;
      ls_valid_d = 1'b0;
      mem_a_d    = '0;
      mem_wr_d   = 1'b0;
      mem_dout_d = mem_dout_q;
      iss_d      = 1'b0;
      dv_d       = iss_q;
      rd_go      = 1'b0;
      wr_go      = 1'b0;
      ib         = base_q;
      ik         = k_q;
      wd         = wdata_q;

      unique case (state_q)
         S_IDLE: begin
            k_d   = '0;
            cap_d = '0;
            asm_d = '0;
            // The first byte goes out on the accepting edge itself.
            if (ls_en) begin
               base_d  = ls_addr;
               n_d     = ls_bytes(ls_width);
               wdata_d = ls_wdata;
               ib      = ls_addr;
               ik      = '0;
               wd      = ls_wdata;
               if (ls_wr) begin
                  state_d = S_LS_WR;
                  wr_go   = 1'b1;
               end else begin
                  state_d = S_LS_RD;
                  rd_go   = 1'b1;
               end
            end else if (ic_en && !clear) begin
               base_d  = ic_addr;
               n_d     = 4'(LINE_BYTES);
               ib      = ic_addr;
               ik      = '0;
               state_d = S_IC_RD;
               rd_go   = 1'b1;
            end
         end
         S_IC_RD, S_LS_RD: begin
            if (state_q == S_IC_RD && clear) begin
               state_d = S_IDLE;
               dv_d    = 1'b0;
            end else begin
               rd_go = (k_q != n_q);
               if (dv_q) begin
                  asm_d[{cap_q[2:0], 3'b000} +: 8] = mem_din;
                  cap_d = cap_q + 4'd1;
                  if (cap_q == n_q - 4'd1) begin
                     state_d = S_DONE;
                     if (state_q == S_IC_RD) begin
                        ic_blk_d   = asm_d;
                        ic_valid_d = 1'b1;
                     end else begin
                        ls_rdata_d = asm_d[31:0];
                        ls_valid_d = 1'b1;
                     end
                  end
               end
            end
         end
         S_LS_WR: begin
            if (k_q == n_q) begin
               state_d    = S_DONE;
               ls_valid_d = 1'b1;
            end else begin
               wr_go = 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      tgt = ib + ADDR_W'(ik);
      if (rd_go) begin
         mem_a_d = tgt;
         iss_d   = 1'b1;
         k_d     = ik + 4'd1;
      end
      // A full IO buffer holds the write byte back; the bus stays idle.
      if (wr_go && !(tgt[17:16] == IO_HI && io_buffer_full)) begin
         mem_a_d    = tgt;
         mem_wr_d   = 1'b1;
         mem_dout_d = wd[{ik[1:0], 3'b000} +: 8];
         k_d        = ik + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         n_q        <= '0;
         k_q        <= '0;
         cap_q      <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         ic_blk_q   <= '0;
         ls_rdata_q <= '0;
         ic_valid_q <= 1'b0;
         ls_valid_q <= 1'b0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         iss_q      <= 1'b0;
         dv_q       <= 1'b0;
      end else if (rdy) begin
         state_q    <= state_d;
         base_q     <= base_d;
         n_q        <= n_d;
         k_q        <= k_d;
         cap_q      <= cap_d;
         wdata_q    <= wdata_d;
         asm_q      <= asm_d;
         ic_blk_q   <= ic_blk_d;
         ls_rdata_q <= ls_rdata_d;
         ic_valid_q <= ic_valid_d;
         ls_valid_q <= ls_valid_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         iss_q      <= iss_d;
         dv_q       <= dv_d;
      end
   end

   assign mem_a    = mem_a_q;
   assign mem_dout = mem_dout_q;
   assign mem_wr   = mem_wr_q & rdy;
   assign ic_valid = ic_valid_q;
   assign ic_blk   = ic_blk_q;
   assign ls_valid = ls_valid_q;
   assign ls_rdata = ls_rdata_q;

endmodule
